usb_host_bus_sched: RTL and testbench

// Host-side scheduler for the shared full-speed USB D+/D- pair in the device bench.

---
 rtl/usb_host_bus_sched.sv | 213 +++++++++++++++++++++
 tb/tb_usb_host_bus_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_bus_sched.sv
// usb_host_bus_sched: host-side scheduler for the shared full-speed USB pair.
// Round-robin arbitrates NREQ sequencers, owns the host line driver enable for
// one transaction at a time, tracks the device response window and enforces
// the inter-packet gap before the next grant.
// Ports:
//   clk48        48 MHz clock, rising edge
//   reset        asynchronous active-low reset
//   req          per-requester level request (held until done/abort)
//   expect_rsp   per-requester response-expected flag, sampled at grant
//   host_tx_busy host transmitter is driving a packet
//   dev_tx_en    device output enable
//   grant        one-hot grant (registered)
//   host_oe      host driver enable (registered)
//   done         1-cycle pulse at end of a granted transaction
//   timeout      1-cycle pulse with done: no device response in the window
//   collision    1-cycle pulse with done: device drove while host_oe was set
//   busy         scheduler not idle
module usb_host_bus_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned IPG_CYC     = 16,
  parameter int unsigned RSP_TIMEOUT = 72
) (
  input  logic            clk48,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] expect_rsp,
  input  logic            host_tx_busy,
  input  logic            dev_tx_en,
  output logic [NREQ-1:0] grant,
  output logic            host_oe,
  output logic            done,
  output logic            timeout,
  output logic            collision,
  output logic            busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GW = $clog2(IPG_CYC + 1);
  localparam int unsigned RW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HOST_TX, S_WAIT_RSP, S_DEV_RX, S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            host_oe_q, host_oe_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            collision_q, collision_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   own_q, own_d;
  logic            exp_q, exp_d;
  logic            seen_q, seen_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [RW-1:0]   rsp_q, rsp_d;

  logic            win_vld;
  logic [PW-1:0]   win_idx;
  int unsigned     cand;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr_q) + k) % NREQ;
      if (!win_vld && req[PW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = PW'(cand);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    host_oe_d   = host_oe_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    collision_d = 1'b0;
    rr_d        = rr_q;
    own_d       = own_q;
    exp_d       = exp_q;
    seen_d      = seen_q;
    gap_d       = gap_q;
    rsp_d       = rsp_q;

    // Gap counter: counts quiet cycles, any device activity restarts it.
    if (state_q == S_IDLE || state_q == S_GAP) begin
      if (dev_tx_en) begin
        gap_d = '0;
      end else if (!host_oe_q && gap_q < GW'(IPG_CYC)) begin
        gap_d = gap_q + GW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (win_vld && gap_q >= GW'(IPG_CYC)) begin
          state_d   = S_HOST_TX;
          grant_d   = NREQ'(1) << win_idx;
          host_oe_d = 1'b1;
          exp_d     = expect_rsp[win_idx];
          own_d     = win_idx;
          seen_d    = 1'b0;
          rr_d      = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end
      end
      S_HOST_TX: begin
        seen_d = seen_q | host_tx_busy;
        if (dev_tx_en && host_oe_q) begin
          // Device drove into our packet: collision wins over everything.
          grant_d     = '0;
          host_oe_d   = 1'b0;
          done_d      = 1'b1;
          collision_d = 1'b1;
          gap_d       = '0;
          state_d     = S_GAP;
        end else if (!seen_q && !host_tx_busy && !req[own_q]) begin
          // Requester withdrew before its packet started: silent release.
          grant_d   = '0;
          host_oe_d = 1'b0;
          gap_d     = '0;
          state_d   = S_GAP;
        end else if (seen_q && !host_tx_busy) begin
          grant_d   = '0;
          host_oe_d = 1'b0;
          if (exp_q) begin
            rsp_d   = '0;
            state_d = S_WAIT_RSP;
          end else begin
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_WAIT_RSP: begin
        // A response on the last window cycle still counts.
        if (dev_tx_en) begin
          state_d = S_DEV_RX;
        end else if (rsp_q == RW'(RSP_TIMEOUT - 1)) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          gap_d     = '0;
          state_d   = S_GAP;
        end else begin
          rsp_d = rsp_q + RW'(1);
        end
      end
      S_DEV_RX: begin
        if (!dev_tx_en) begin
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q >= GW'(IPG_CYC)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; gap starts satisfied out of reset.
  always_ff @(posedge clk48 or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      host_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      collision_q <= 1'b0;
      busy_q      <= 1'b0;
      rr_q        <= '0;
      own_q       <= '0;
      exp_q       <= 1'b0;
      seen_q      <= 1'b0;
      gap_q       <= GW'(IPG_CYC);
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      host_oe_q   <= host_oe_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      collision_q <= collision_d;
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      own_q       <= own_d;
      exp_q       <= exp_d;
      seen_q      <= seen_d;
      gap_q       <= gap_d;
      rsp_q       <= rsp_d;
    end
  end

  assign grant     = grant_q;
  assign host_oe   = host_oe_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign collision = collision_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_usb_host_bus_sched.sv
// Testbench for usb_host_bus_sched: directed spec scenarios plus randomized
// transactions. Expected grant order comes from a round-robin pick over the
// request mask; expected outcomes and timings come from the transaction rules.
module tb_usb_host_bus_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IPG  = 16;
  localparam int unsigned RSPT = 72;

  logic            clk48 = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] expect_rsp = '0;
  logic            host_tx_busy = 1'b0;
  logic            dev_tx_en = 1'b0;
  logic [NREQ-1:0] grant;
  logic            host_oe, done, timeout, collision, busy;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int rr_m    = 0;
  int end_cyc = 0;

  usb_host_bus_sched #(.NREQ(NREQ), .IPG_CYC(IPG), .RSP_TIMEOUT(RSPT)) dut (
    .clk48(clk48), .reset(reset), .req(req), .expect_rsp(expect_rsp),
    .host_tx_busy(host_tx_busy), .dev_tx_en(dev_tx_en), .grant(grant),
    .host_oe(host_oe), .done(done), .timeout(timeout), .collision(collision),
    .busy(busy)
  );

  always #5 clk48 = ~clk48;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk48);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first requester at or after the pointer.
  function automatic int rr_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic grant_txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] e,
                           input bit gap_req, output int w, output int lat);
    logic [NREQ-1:0] exp_g;
    req        = r;
    expect_rsp = e;
    w          = rr_pick(r);
    exp_g      = NREQ'(1) << w;
    lat        = 0;
    do begin
      step();
      lat++;
    end while (grant === '0 && lat < 400);
    chk("grant_onehot", 32'(grant), 32'(exp_g));
    chk("grant_host_oe", 32'(host_oe), 1);
    chk("grant_busy", 32'(busy), 1);
    if (gap_req) chk("ipg_respected", 32'(cyc - end_cyc >= int'(IPG) + 1), 1);
    rr_m = (w + 1) % NREQ;
  endtask

  task automatic end_ok(input string tag, input bit t, input bit c);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
    chk({tag, "_collision"}, 32'(collision), 32'(c));
    chk({tag, "_grant_rel"}, 32'(grant), 0);
    chk({tag, "_oe_rel"}, 32'(host_oe), 0);
    end_cyc = cyc;
    step();
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  task automatic host_pkt(input int len);
    host_tx_busy = 1'b1;
    repeat (len) step();
    chk("oe_held_in_tx", 32'(host_oe), 1);
    host_tx_busy = 1'b0;
    step();
  endtask

  task automatic txn_norsp(input int len);
    host_pkt(len);
    end_ok("norsp", 1'b0, 1'b0);
  endtask

  task automatic txn_rsp(input int len, input int d, input int h);
    host_pkt(len);
    chk("wait_rsp_oe", 32'(host_oe), 0);
    chk("wait_rsp_nodone", 32'(done), 0);
    repeat (d) step();
    dev_tx_en = 1'b1;
    repeat (h) step();
    chk("dev_rx_nodone", 32'(done), 0);
    chk("dev_rx_busy", 32'(busy), 1);
    dev_tx_en = 1'b0;
    step();
    end_ok("rsp", 1'b0, 1'b0);
  endtask

  // No response: done+timeout exactly RSPT cycles after host_oe drops.
  task automatic txn_to(input int len);
    host_pkt(len);
    repeat (RSPT - 1) step();
    chk("no_early_timeout", 32'(done), 0);
    step();
    end_ok("timeout", 1'b1, 1'b0);
  endtask

  task automatic txn_col(input int k);
    host_tx_busy = 1'b1;
    repeat (k) step();
    dev_tx_en = 1'b1;
    step();
    dev_tx_en    = 1'b0;
    host_tx_busy = 1'b0;
    end_ok("collision", 1'b0, 1'b1);
  endtask

  task automatic txn_abort(input int w, input logic [NREQ-1:0] new_req);
    req = new_req & ~(NREQ'(1) << w);
    step();
    chk("abort_grant", 32'(grant), 0);
    chk("abort_oe", 32'(host_oe), 0);
    chk("abort_nodone", 32'(done), 0);
    chk("abort_busy", 32'(busy), 1);
    end_cyc = cyc;
  endtask

  initial begin
    int w, lat, c;
    logic [NREQ-1:0] r, e;

    // Reset state.
    repeat (3) step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_oe", 32'(host_oe), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_collision", 32'(collision), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    step();

    // Single requester, no response, 40-cycle packet; first grant needs no gap.
    grant_txn(4'b0001, 4'b0000, 1'b0, w, lat);
    chk("first_grant_latency", 32'(lat), 1);
    txn_norsp(40);

    // All requesting: rotation.
    for (int i = 0; i < 5; i++) begin
      grant_txn(4'b1111, 4'b0000, 1'b1, w, lat);
      txn_norsp(12);
    end

    // Response 30 cycles after EOP, held 40.
    grant_txn(4'b0010, 4'b0010, 1'b1, w, lat);
    txn_rsp(20, 30, 40);

    // No response: timeout.
    grant_txn(4'b0100, 4'b0100, 1'b1, w, lat);
    txn_to(16);

    // Response on the final window cycle wins over timeout.
    grant_txn(4'b1000, 4'b1000, 1'b1, w, lat);
    txn_rsp(10, int'(RSPT) - 1, 3);

    // Collision during host packet.
    grant_txn(4'b0001, 4'b0000, 1'b1, w, lat);
    txn_col(5);

    // Abort by req[2] before its packet, then req[3] after the gap.
    grant_txn(4'b0100, 4'b0000, 1'b1, w, lat);
    txn_abort(w, 4'b1000);
    grant_txn(4'b1000, 4'b0000, 1'b1, w, lat);
    chk("after_abort_winner", 32'(w), 3);
    txn_norsp(10);

    // Randomized transactions.
    for (int i = 0; i < 24; i++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      e = NREQ'($urandom);
      grant_txn(r, e, 1'b1, w, lat);
      c = $urandom_range(0, 5);
      if (c == 0)       txn_col($urandom_range(1, 10));
      else if (c == 1)  txn_abort(w, r);
      else if (e[w])    begin
        if (c[0]) txn_rsp($urandom_range(8, 30), $urandom_range(0, RSPT - 1), $urandom_range(1, 20));
        else      txn_to($urandom_range(8, 30));
      end
      else              txn_norsp($urandom_range(8, 30));
    end

    // Reset during device response.
    grant_txn(4'b0010, 4'b0010, 1'b1, w, lat);
    host_pkt(12);
    dev_tx_en = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rstmid_grant", 32'(grant), 0);
    chk("rstmid_oe", 32'(host_oe), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_done", 32'(done), 0);
    step();
    dev_tx_en = 1'b0;
    reset     = 1'b1;
    rr_m      = 0;
    grant_txn(4'b0110, 4'b0000, 1'b0, w, lat);
    chk("post_rst_latency", 32'(lat), 1);
    txn_norsp(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
